ysyx_23060201_mem_arbiter: RTL and testbench
============================================

YSYX_23060201_MEM_ARBITER -- requirements
Module: ysyx_23060201_mem_arbiter

Interface
REQ-001 SHALL have parameter MBASE, default 32'h8000_0000, lowest valid physical address.
REQ-002 SHALL have parameter MSIZE, default 32'h0800_0000, size in bytes of the valid memory window.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ifu_req_valid  input  1  IFU fetch request.
REQ-006 SHALL have port ifu_req_ready  output  1  IFU request accepted this cycle.
REQ-007 SHALL have port ifu_addr  input  32  IFU fetch address (pc).
REQ-008 SHALL have port ifu_resp_valid  output  1  IFU response available.
REQ-009 SHALL have port ifu_resp_ready  input  1  IFU accepts response.
REQ-010 SHALL have port ifu_rdata  output  32  instruction word.
REQ-011 SHALL have port lsu_req_valid  input  1  LSU access request.
REQ-012 SHALL have port lsu_req_ready  output  1  LSU request accepted this cycle.
REQ-013 SHALL have port lsu_addr  input  32  LSU address.
REQ-014 SHALL have port lsu_wdata  input  32  store data.
REQ-015 SHALL have port lsu_wmask  input  4  byte write mask; 0 = load.
REQ-016 SHALL have port lsu_resp_valid  output  1  LSU response available.
REQ-017 SHALL have port lsu_resp_ready  input  1  LSU accepts response.
REQ-018 SHALL have port lsu_rdata  output  32  load data.
REQ-019 SHALL have port mem_req_valid  output  1  request to memory.
REQ-020 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-021 SHALL have port mem_addr  output  32  offset address (addr - MBASE).
REQ-022 SHALL have port mem_wdata  output  32  store data.
REQ-023 SHALL have port mem_wmask  output  4  byte mask; always 0 for IFU requests.
REQ-024 SHALL have port mem_resp_valid  input  1  memory response, one-cycle pulse, never in the cycle of the mem_req handshake.
REQ-025 SHALL have port mem_rdata  input  32  memory read data, valid with mem_resp_valid.

Function
REQ-026 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one transaction outstanding at a time.
REQ-027 In IDLE only: ifu_req_ready/lsu_req_ready SHALL be combinational, high solely for the granted valid requester.
REQ-028 Req handshake SHALL latch addr, wdata, wmask (IFU: 0) and owner; in-range -> ISSUE, out-of-range -> RESP with buffered rdata 32'h0, no memory access.
REQ-029 In-range SHALL be addr >= MBASE && (addr - MBASE) < MSIZE, 32-bit unsigned, no wrap.
REQ-030 ISSUE: mem_req_valid=1, fields stable until mem_req_ready; then WAIT.
REQ-031 WAIT: mem_resp_valid SHALL capture mem_rdata into the response buffer -> RESP; mem_resp_valid in any other state SHALL be ignored.
REQ-032 RESP: owner resp_valid=1 with buffered rdata, held stable until owner resp_ready; then IDLE; non-owner resp_valid=0.
REQ-033 Minimum latency: handshake cycle T, mem_req_valid T+1, mem_resp_valid T+2, resp_valid T+3; next grant T+4 at earliest.
REQ-034 Stores (wmask!=0) SHALL also produce a response; rdata = mem_rdata as returned.
REQ-035 Default arbitration: fixed priority, LSU over IFU on simultaneous requests.

Reset
REQ-036 On rst_n low: state IDLE, all *_ready/*_valid outputs 0, latched addr/wdata/wmask/rdata 0, RR pointer favours LSU.
REQ-037 Reset mid-transaction SHALL abandon it immediately; late mem_resp_valid after release SHALL be ignored.

Configuration
REQ-038 Macro YSYX_23060201_ARB_RR_EN defined: round-robin; requester not granted last wins ties; pointer updates on each accepted request. Undefined: REQ-035 fixed priority, no pointer register.

Structure
REQ-039 Package ysyx_23060201_pkg SHALL hold FSM state typedef, requester-ID typedef (IFU/LSU) and MBASE/MSIZE defaults.
REQ-040 Grant logic SHALL be sub-module ysyx_23060201_arb_pick (valids + pointer -> one-hot grant).

Verification
REQ-041 IFU alone, addr 32'h8000_0004, mem_rdata 32'h0000_0413 at T+2 -> mem_addr 32'h4, ifu_rdata 32'h0000_0413 with ifu_resp_valid at T+3.
REQ-042 IFU and LSU valid same cycle -> LSU granted first (fixed); with RR_EN, repeated contention alternates LSU, IFU, LSU.
REQ-043 LSU store addr 32'h8000_0100, wdata 32'hDEAD_BEEF, wmask 4'hF -> mem_addr 32'h100, wmask 4'hF; lsu_resp_valid after memory response.
REQ-044 IFU addr 32'h0000_0000 and 32'h8800_0000 -> no mem_req_valid, ifu_rdata 0 at T+1.
REQ-045 mem_req_ready low 3 cycles, then resp_ready low 2 cycles -> mem_* and rdata held stable, no new grant until resp handshake.
REQ-046 rst_n pulsed low in WAIT -> IDLE, outputs 0; stray mem_resp_valid afterwards -> no resp_valid.

Source files
------------

// File: rtl/ysyx_23060201_pkg.sv
// Shared types and defaults for the memory arbiter: FSM encoding, requester IDs,
// and the physical memory window.
package ysyx_23060201_pkg;

    localparam logic [31:0] MBASE_DEF = 32'h8000_0000;
    localparam logic [31:0] MSIZE_DEF = 32'h0800_0000;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ISSUE = 2'd1;
    localparam state_t S_WAIT  = 2'd2;
    localparam state_t S_RESP  = 2'd3;

    typedef enum logic {
        ID_IFU = 1'b0,
        ID_LSU = 1'b1
    } req_id_t;

    // Subtraction only happens once addr >= base, so the offset never wraps.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
        return (addr >= base) && ((addr - base) < size);
    endfunction

endpackage

// File: rtl/ysyx_23060201_arb_pick.sv
// Two-requester grant picker: a lone requester always wins, ties go to the
// requester named by ptr.
module ysyx_23060201_arb_pick
    import ysyx_23060201_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid[ID_LSU] && (ptr == ID_LSU || !valid[ID_IFU]))
            grant[ID_LSU] = 1'b1;
        else if (valid[ID_IFU])
            grant[ID_IFU] = 1'b1;
    end

endmodule

// File: rtl/ysyx_23060201_mem_arbiter.sv
// IFU/LSU arbiter onto a single memory port, one transaction in flight.
// Define YSYX_23060201_ARB_RR_EN for round-robin; otherwise LSU has fixed priority.
module ysyx_23060201_mem_arbiter
    import ysyx_23060201_pkg::*;
#(
    parameter logic [31:0] MBASE = MBASE_DEF,
    parameter logic [31:0] MSIZE = MSIZE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    req_id_t     owner;
    req_id_t     ptr;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic [31:0] rdata_q;
    logic [1:0]  grant;
    logic        idle;
    logic        req_hs;
    logic        pick_lsu;
    logic [31:0] sel_addr;

    ysyx_23060201_arb_pick u_pick (
        .valid (lsu_req_valid ? {1'b1, ifu_req_valid} : {1'b0, ifu_req_valid}),
        .ptr   (ptr),
        .grant (grant)
    );

    // Gating with rst_n keeps the combinational readies low while reset is held.
    assign idle          = (state == S_IDLE) && rst_n;
    assign ifu_req_ready = idle && grant[ID_IFU];
    assign lsu_req_ready = idle && grant[ID_LSU];
    assign req_hs        = ifu_req_ready || lsu_req_ready;
    assign pick_lsu      = grant[ID_LSU];
    assign sel_addr      = pick_lsu ? lsu_addr : ifu_addr;

`ifdef YSYX_23060201_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= ID_LSU;
        else if (req_hs)
            ptr <= pick_lsu ? ID_IFU : ID_LSU;
    end
`else
    assign ptr = ID_LSU;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            owner   <= ID_IFU;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wmask_q <= 4'h0;
            rdata_q <= 32'h0;
        end else begin
            case (state)
                S_IDLE: if (req_hs) begin
                    owner   <= pick_lsu ? ID_LSU : ID_IFU;
                    addr_q  <= sel_addr - MBASE;
                    wdata_q <= pick_lsu ? lsu_wdata : 32'h0;
                    wmask_q <= pick_lsu ? lsu_wmask : 4'h0;
                    if (in_range(sel_addr, MBASE, MSIZE)) begin
                        state <= S_ISSUE;
                    end else begin
                        // Out-of-window access completes locally with zero data.
                        rdata_q <= 32'h0;
                        state   <= S_RESP;
                    end
                end
                S_ISSUE: if (mem_req_ready) state <= S_WAIT;
                S_WAIT: if (mem_resp_valid) begin
                    rdata_q <= mem_rdata;
                    state   <= S_RESP;
                end
                S_RESP: begin
                    if ((owner == ID_IFU && ifu_resp_ready) ||
                        (owner == ID_LSU && lsu_resp_ready))
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_req_valid  = (state == S_ISSUE);
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign ifu_resp_valid = (state == S_RESP) && (owner == ID_IFU);
    assign lsu_resp_valid = (state == S_RESP) && (owner == ID_LSU);
    assign ifu_rdata      = rdata_q;
    assign lsu_rdata      = rdata_q;

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Directed bench for the memory arbiter; expected values are hand-computed.
module tb_ysyx_23060201_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_23060201_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the cycle after a request handshake (ISSUE, mem ready) through the
    // response handshake; leaves the bench one cycle into IDLE.
    task automatic serve(input string tag, input logic [31:0] rd, input logic lsu_own);
        tick();                                 // now WAIT
        mem_resp_valid = 1'b1; mem_rdata = rd;
        tick();                                 // now RESP
        mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        #1;
        chk({tag, "_ifu_resp_valid"}, {31'h0, ifu_resp_valid}, {31'h0, !lsu_own});
        chk({tag, "_lsu_resp_valid"}, {31'h0, lsu_resp_valid}, {31'h0, lsu_own});
        chk({tag, "_rdata"}, lsu_own ? lsu_rdata : ifu_rdata, rd);
        if (lsu_own) lsu_resp_ready = 1'b1; else ifu_resp_ready = 1'b1;
        tick();                                 // back to IDLE
        lsu_resp_ready = 1'b0; ifu_resp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; ifu_resp_ready = 1'b0;
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        lsu_resp_ready = 1'b0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = 32'h0;

        // Reset state, including ready held low with a pending request
        tick(); tick();
        chk("rst_ifu_req_ready", {31'h0, ifu_req_ready}, 32'h0);
        chk("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
        chk("rst_resp_valid", {30'h0, ifu_resp_valid, lsu_resp_valid}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rdata", ifu_rdata, 32'h0);
        ifu_req_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // IFU fetch at minimum latency
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
        #1;
        chk("ifu_req_ready", {31'h0, ifu_req_ready}, 32'h1);
        chk("ifu_lsu_ready", {31'h0, lsu_req_ready}, 32'h0);
        tick();                                 // T+1
        ifu_req_valid = 1'b0;
        #1;
        chk("ifu_mem_req_valid", {31'h0, mem_req_valid}, 32'h1);
        chk("ifu_mem_addr", mem_addr, 32'h0000_0004);
        chk("ifu_mem_wmask", {28'h0, mem_wmask}, 32'h0);
        serve("ifu", 32'h0000_0413, 1'b0);
        chk("ifu_done", {31'h0, ifu_resp_valid}, 32'h0);

        // Contention: both keep requesting for three grants
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0008; lsu_wmask = 4'h0;
        #1;
        chk("cont1_lsu_ready", {31'h0, lsu_req_ready}, 32'h1);
        chk("cont1_ifu_ready", {31'h0, ifu_req_ready}, 32'h0);
        tick();
        #1;
        chk("cont1_mem_addr", mem_addr, 32'h0000_0008);
        chk("cont1_busy_ifu_ready", {31'h0, ifu_req_ready}, 32'h0);
        serve("cont1", 32'h1111_1111, 1'b1);
        #1;
`ifdef YSYX_23060201_ARB_RR_EN
        chk("cont2_ifu_ready", {31'h0, ifu_req_ready}, 32'h1);
        tick();
        #1;
        chk("cont2_mem_addr", mem_addr, 32'h0000_0010);
        serve("cont2", 32'h2222_2222, 1'b0);
`else
        chk("cont2_lsu_ready", {31'h0, lsu_req_ready}, 32'h1);
        tick();
        #1;
        chk("cont2_mem_addr", mem_addr, 32'h0000_0008);
        serve("cont2", 32'h2222_2222, 1'b1);
`endif
        #1;
        chk("cont3_lsu_ready", {31'h0, lsu_req_ready}, 32'h1);
        tick();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        serve("cont3", 32'h3333_3333, 1'b1);

        // LSU store
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        #1;
        chk("st_lsu_ready", {31'h0, lsu_req_ready}, 32'h1);
        tick();
        lsu_req_valid = 1'b0; lsu_wmask = 4'h0;
        #1;
        chk("st_mem_addr", mem_addr, 32'h0000_0100);
        chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st_mem_wmask", {28'h0, mem_wmask}, 32'hF);
        serve("st", 32'h1234_5678, 1'b1);

        // Out-of-window fetches complete locally with zero data at T+1
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0000;
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk("oor0_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
        chk("oor0_resp_valid", {31'h0, ifu_resp_valid}, 32'h1);
        chk("oor0_rdata", ifu_rdata, 32'h0);
        ifu_resp_ready = 1'b1;
        tick();
        ifu_resp_ready = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8800_0000;
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk("oor_top_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
        chk("oor_top_resp_valid", {31'h0, ifu_resp_valid}, 32'h1);
        ifu_resp_ready = 1'b1;
        tick();
        ifu_resp_ready = 1'b0;

        // Last word of the window is still in range
        ifu_req_valid = 1'b1; ifu_addr = 32'h87FF_FFFC;
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk("edge_mem_req_valid", {31'h0, mem_req_valid}, 32'h1);
        chk("edge_mem_addr", mem_addr, 32'h07FF_FFFC);
        serve("edge", 32'hAAAA_5555, 1'b0);

        // Backpressure on both memory request and response
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0020; mem_req_ready = 1'b0;
        tick();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_mem_req_valid", {31'h0, mem_req_valid}, 32'h1);
            chk("bp_mem_addr", mem_addr, 32'h0000_0020);
            chk("bp_lsu_ready", {31'h0, lsu_req_ready}, 32'h0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();                                 // WAIT
        mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();                                 // RESP
        mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bp_resp_valid", {31'h0, ifu_resp_valid}, 32'h1);
            chk("bp_rdata", ifu_rdata, 32'hCAFE_F00D);
            chk("bp_resp_lsu_ready", {31'h0, lsu_req_ready}, 32'h0);
            tick();
        end
        ifu_resp_ready = 1'b1;
        tick();
        ifu_resp_ready = 1'b0;
        #1;
        chk("bp_next_grant", {31'h0, lsu_req_ready}, 32'h1);

        // Reset while waiting on memory, then a stray response
        tick();                                 // ISSUE
        lsu_req_valid = 1'b0;
        tick();                                 // WAIT
        rst_n = 1'b0;
        #1;
        chk("rstw_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
        chk("rstw_mem_addr", mem_addr, 32'h0);
        chk("rstw_rdata", lsu_rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        mem_resp_valid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        tick();
        mem_resp_valid = 1'b0;
        tick();
        #1;
        chk("rstw_lsu_resp_valid", {31'h0, lsu_resp_valid}, 32'h0);
        chk("rstw_ifu_resp_valid", {31'h0, ifu_resp_valid}, 32'h0);
        chk("rstw_rdata_after", lsu_rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
